// File: rtl/id_ex_register.sv
// Decode-to-Execute pipeline register: holds on stall, injects bubbles on flush
// or invalid input, and keeps a saturating count of injected bubbles.
module id_ex_register #(
  parameter logic [2:0] NOP_S2 = 3'b101,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_PC,
  input  logic [31:0]      id_PA,
  input  logic [31:0]      id_PB,
  input  logic [2:0]       id_S2,
  input  logic [3:0]       id_alu_op,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_we,
  input  logic             id_mem_rd,
  input  logic             id_mem_we,
  output logic             ex_valid,
  output logic [31:0]      ex_PA,
  output logic [31:0]      ex_PB,
  output logic [31:0]      ex_PC,
  output logic [11:0]      ex_imm12_I,
  output logic [11:0]      ex_imm12_S,
  output logic [19:0]      ex_imm20,
  output logic [2:0]       ex_S2,
  output logic [3:0]       ex_alu_op,
  output logic [4:0]       ex_rd,
  output logic             ex_rf_we,
  output logic             ex_mem_rd,
  output logic             ex_mem_we,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage control: flush beats stall; stall freezes everything including the
  // counter; an invalid Decode slot turns into a counted bubble.
  logic load_bubble;
  logic load_instr;

  assign load_bubble = flush | (~stall & ~id_valid);
  assign load_instr  = ~flush & ~stall & id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_PA        <= '0;
      ex_PB        <= '0;
      ex_PC        <= '0;
      ex_imm12_I   <= '0;
      ex_imm12_S   <= '0;
      ex_imm20     <= '0;
      ex_S2        <= NOP_S2;
      ex_alu_op    <= '0;
      ex_rd        <= '0;
      ex_rf_we     <= 1'b0;
      ex_mem_rd    <= 1'b0;
      ex_mem_we    <= 1'b0;
      bubble_count <= '0;
    end else if (load_bubble) begin
      ex_valid     <= 1'b0;
      ex_PA        <= '0;
      ex_PB        <= '0;
      ex_PC        <= '0;
      ex_imm12_I   <= '0;
      ex_imm12_S   <= '0;
      ex_imm20     <= '0;
      ex_S2        <= NOP_S2;
      ex_alu_op    <= '0;
      ex_rd        <= '0;
      ex_rf_we     <= 1'b0;
      ex_mem_rd    <= 1'b0;
      ex_mem_we    <= 1'b0;
      if (bubble_count != CNT_MAX) begin
        bubble_count <= bubble_count + CNT_ONE;
      end
    end else if (load_instr) begin
      // Immediates are raw slices; sign extension happens in the operand stage.
      ex_valid     <= 1'b1;
      ex_PA        <= id_PA;
      ex_PB        <= id_PB;
      ex_PC        <= id_PC;
      ex_imm12_I   <= id_instr[31:20];
      ex_imm12_S   <= {id_instr[31:25], id_instr[11:7]};
      ex_imm20     <= id_instr[31:12];
      ex_S2        <= id_S2;
      ex_alu_op    <= id_alu_op;
      ex_rd        <= id_rd;
      ex_rf_we     <= id_rf_we;
      ex_mem_rd    <= id_mem_rd;
      ex_mem_we    <= id_mem_we;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: reset, load, stall, flush, invalid input
// and counter saturation (second instance with a 4-bit counter).
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, id_valid;
  logic [31:0] id_instr, id_PC, id_PA, id_PB;
  logic [2:0]  id_S2;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rd;
  logic        id_rf_we, id_mem_rd, id_mem_we;

  logic        ex_valid;
  logic [31:0] ex_PA, ex_PB, ex_PC;
  logic [11:0] ex_imm12_I, ex_imm12_S;
  logic [19:0] ex_imm20;
  logic [2:0]  ex_S2;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic        ex_rf_we, ex_mem_rd, ex_mem_we;
  logic [15:0] bubble_count;

  logic        s_valid;
  logic [31:0] s_PA, s_PB, s_PC;
  logic [11:0] s_imm12_I, s_imm12_S;
  logic [19:0] s_imm20;
  logic [2:0]  s_S2;
  logic [3:0]  s_alu_op;
  logic [4:0]  s_rd;
  logic        s_rf_we, s_mem_rd, s_mem_we;
  logic [3:0]  s_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt;
  logic [3:0]  exp_cnt4;
  logic [3:0]  exp_q[$];

  id_ex_register dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_instr(id_instr), .id_PC(id_PC), .id_PA(id_PA), .id_PB(id_PB),
    .id_S2(id_S2), .id_alu_op(id_alu_op), .id_rd(id_rd),
    .id_rf_we(id_rf_we), .id_mem_rd(id_mem_rd), .id_mem_we(id_mem_we),
    .ex_valid(ex_valid), .ex_PA(ex_PA), .ex_PB(ex_PB), .ex_PC(ex_PC),
    .ex_imm12_I(ex_imm12_I), .ex_imm12_S(ex_imm12_S), .ex_imm20(ex_imm20),
    .ex_S2(ex_S2), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .ex_rf_we(ex_rf_we), .ex_mem_rd(ex_mem_rd), .ex_mem_we(ex_mem_we),
    .bubble_count(bubble_count)
  );

  id_ex_register #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_instr(id_instr), .id_PC(id_PC), .id_PA(id_PA), .id_PB(id_PB),
    .id_S2(id_S2), .id_alu_op(id_alu_op), .id_rd(id_rd),
    .id_rf_we(id_rf_we), .id_mem_rd(id_mem_rd), .id_mem_we(id_mem_we),
    .ex_valid(s_valid), .ex_PA(s_PA), .ex_PB(s_PB), .ex_PC(s_PC),
    .ex_imm12_I(s_imm12_I), .ex_imm12_S(s_imm12_S), .ex_imm20(s_imm20),
    .ex_S2(s_S2), .ex_alu_op(s_alu_op), .ex_rd(s_rd),
    .ex_rf_we(s_rf_we), .ex_mem_rd(s_mem_rd), .ex_mem_we(s_mem_we),
    .bubble_count(s_count)
  );

  // Clock/reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, 64'(ex_valid), 64'd0);
    check({tag, ".S2"}, 64'(ex_S2), 64'd5);
    check({tag, ".alu_op"}, 64'(ex_alu_op), 64'd0);
    check({tag, ".rd"}, 64'(ex_rd), 64'd0);
    check({tag, ".PA"}, 64'(ex_PA), 64'd0);
    check({tag, ".PB"}, 64'(ex_PB), 64'd0);
    check({tag, ".PC"}, 64'(ex_PC), 64'd0);
    check({tag, ".imm"}, {ex_imm12_I, ex_imm12_S, ex_imm20}, 64'd0);
    check({tag, ".en"}, {ex_rf_we, ex_mem_rd, ex_mem_we}, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] pa, input logic [31:0] pb, input logic [2:0] s2,
                       input logic [3:0] op, input logic [4:0] rd, input logic [2:0] en);
    id_valid = v; id_instr = instr; id_PC = pc; id_PA = pa; id_PB = pb;
    id_S2 = s2; id_alu_op = op; id_rd = rd;
    {id_rf_we, id_mem_rd, id_mem_we} = en;
  endtask

  function automatic logic [3:0] sat4(input logic [3:0] c);
    return (c == 4'hF) ? 4'hF : c + 4'd1;
  endfunction

  initial begin
    stall = 0; flush = 0; reset = 1;
    drive(1, 32'hDEADBEEF, 32'h44, 32'h1, 32'h2, 3'b011, 4'h3, 5'd9, 3'b111);

    // Reset with no clock edge yet
    #2;
    check_bubble("reset_async");
    check("reset_cnt", 64'(bubble_count), 64'd0);
    tick();
    reset = 0;
    exp_cnt = 0; exp_cnt4 = 0;

    // Load vector with hand-sliced immediates
    drive(1, 32'hFE5A2E23, 32'h100, 32'h0, 32'd7, 3'b010, 4'h0, 5'd0, 3'b001);
    tick();
    check("load.imm12_S", 64'(ex_imm12_S), 64'hFFC);
    check("load.imm12_I", 64'(ex_imm12_I), 64'hFE5);
    check("load.imm20", 64'(ex_imm20), 64'hFE5A2);
    check("load.PC", 64'(ex_PC), 64'h100);
    check("load.PB", 64'(ex_PB), 64'd7);
    check("load.S2", 64'(ex_S2), 64'd2);
    check("load.en", {ex_rf_we, ex_mem_rd, ex_mem_we}, 64'b001);
    check("load.valid", 64'(ex_valid), 64'd1);
    check("load.cnt", 64'(bubble_count), 64'd0);

    // Invalid input with enables and data set
    drive(0, 32'hFFFFFFFF, 32'h200, 32'h55, 32'h66, 3'b001, 4'hA, 5'd31, 3'b111);
    tick();
    exp_cnt = 1; exp_cnt4 = 1;
    check_bubble("invalid");
    check("invalid.cnt", 64'(bubble_count), 64'(exp_cnt));

    // Instruction A, then a 3-cycle stall while inputs change
    drive(1, 32'h00500093, 32'h300, 32'd11, 32'd22, 3'b001, 4'h2, 5'd1, 3'b100);
    tick();
    check("A.PA", 64'(ex_PA), 64'd11);
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      drive(1'(i), 32'h12345678 + i, 32'h900 + i, 32'hAA, 32'hBB, 3'b110, 4'hF, 5'd7, 3'b011);
      tick();
      check("stall.valid", 64'(ex_valid), 64'd1);
      check("stall.PA", 64'(ex_PA), 64'd11);
      check("stall.PB", 64'(ex_PB), 64'd22);
      check("stall.PC", 64'(ex_PC), 64'h300);
      check("stall.imm12_I", 64'(ex_imm12_I), 64'h005);
      check("stall.ctl", {ex_S2, ex_alu_op, ex_rd}, {3'b001, 4'h2, 5'd1});
      check("stall.en", {ex_rf_we, ex_mem_rd, ex_mem_we}, 64'b100);
      check("stall.cnt", 64'(bubble_count), 64'(exp_cnt));
    end

    // Stall drops: the current inputs (B) load, A is not replayed
    stall = 0;
    drive(1, 32'h8000_0000, 32'h404, 32'd33, 32'd44, 3'b100, 4'h6, 5'd12, 3'b010);
    tick();
    check("B.PA", 64'(ex_PA), 64'd33);
    check("B.PC", 64'(ex_PC), 64'h404);
    check("B.imm20", 64'(ex_imm20), 64'h80000);
    check("B.ctl", {ex_S2, ex_alu_op, ex_rd}, {3'b100, 4'h6, 5'd12});
    check("B.en", {ex_rf_we, ex_mem_rd, ex_mem_we}, 64'b010);

    // Flush and stall together: flush wins
    flush = 1; stall = 1;
    drive(1, 32'h00000013, 32'h500, 32'd1, 32'd2, 3'b000, 4'h1, 5'd3, 3'b100);
    tick();
    exp_cnt = 2; exp_cnt4 = 2;
    check_bubble("flush_stall");
    check("flush_stall.cnt", 64'(bubble_count), 64'(exp_cnt));
    check("flush_stall.cnt4", 64'(s_count), 64'(exp_cnt4));

    // Async reset mid-stall with a valid instruction held
    flush = 0; stall = 0;
    tick();
    check("pre_reset.valid", 64'(ex_valid), 64'd1);
    stall = 1;
    tick();
    #2 reset = 1;
    #1;
    check_bubble("reset_mid");
    check("reset_mid.cnt", 64'(bubble_count), 64'd0);
    tick();
    reset = 0; stall = 0;
    exp_cnt = 0; exp_cnt4 = 0;

    // Saturation: 20 bubbles on the 4-bit instance
    id_valid = 0;
    for (int i = 0; i < 20; i++) begin
      exp_cnt4 = sat4(exp_cnt4);
      exp_cnt  = exp_cnt + 16'd1;
      exp_q.push_back(exp_cnt4);
      tick();
      check("sat.cnt4", 64'(s_count), 64'(exp_q.pop_front()));
    end
    check("sat.cnt4_final", 64'(s_count), 64'd15);
    check("sat.cnt16", 64'(bubble_count), 64'd20);
    drive(1, 32'h00100073, 32'h600, 32'd5, 32'd6, 3'b010, 4'h4, 5'd2, 3'b100);
    tick();
    check("sat.after_load", 64'(s_count), 64'd15);
    check("sat.after_load_valid", 64'(s_valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
